// File: rtl/bt_status_tx_pkg.sv
// Shared constants for the Bluetooth status reporter: header byte, the
// byte-shifter state encoding and the bit-period calculation.
// No logic of its own; imported by bt_status_tx and uart_tx_byte.
package bt_status_tx_pkg;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Clock cycles per serial bit, rounded to the nearest integer.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte shifter with its own baud counter.
// Latency: tx falls on the edge that accepts load; one frame = 10*DIV cycles.
// Backpressure: ready is high in IDLE and in the last cycle of the stop bit.
// Ports: clk100/reset; load+data (byte offer); ready (accepts this cycle); tx (registered line).
module uart_tx_byte
  import bt_status_tx_pkg::*;
#(
  parameter int DIV = 10417
) (
  input  logic       clk100,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int            CW      = $clog2(DIV + 1);
  localparam logic [CW-1:0] TICK_AT = CW'(DIV - 1);

  tx_state_t     state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick;
  logic          take;

  // State register
  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (take) state_nx = ST_START;
      ST_START: if (tick) state_nx = ST_DATA;
      ST_DATA:  if (tick && bit_idx == 3'd7) state_nx = ST_STOP;
      ST_STOP:  if (tick) state_nx = take ? ST_START : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Outputs: accepting a byte at the end of a stop bit lets bytes run
  // back to back with no idle bit between them.
  always_comb begin
    tick  = (cnt == TICK_AT);
    ready = (state == ST_IDLE) || (state == ST_STOP && tick);
  end

  assign take = load & ready;

  // Datapath: the counter restarts at every bit boundary, so each bit is
  // exactly DIV cycles and nothing accumulates across a packet.
  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else if (take) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= data;
      tx      <= 1'b0;
    end else if (state != ST_IDLE) begin
      if (tick) begin
        cnt <= '0;
        case (state)
          ST_START: begin
            tx    <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
          end
          ST_DATA: begin
            if (bit_idx == 3'd7) begin
              tx <= 1'b1;
            end else begin
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end
          default: tx <= 1'b1;
        endcase
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bt_status_tx.sv
// Sends a 3-byte status packet {A5, S, A5^S} over UART on send or input change.
// Latency: tx falls 1 cycle after the triggering edge; pkt_done 30*DIV cycles later.
// Backpressure: triggers while a packet is in flight coalesce into one follow-up packet.
// Ports: clk100/reset; speed, turn, SwitchManager (status); send (request);
//        tx (serial line), busy (packet in flight), pkt_done (end pulse).
module bt_status_tx
  import bt_status_tx_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk100,
  input  logic       reset,
  input  logic [3:0] speed,
  input  logic       turn,
  input  logic       SwitchManager,
  input  logic       send,
  output logic       tx,
  output logic       busy,
  output logic       pkt_done
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);

  logic [5:0] in_q;       // {SwitchManager, turn, speed}
  logic [5:0] prev_q;
  logic [7:0] snap_q;
  logic [1:0] idx_q;
  logic       go_q, pending_q, busy_q, done_q;
  logic       trig, byte_end, pkt_end, start_now, load, u_ready;
  logic [7:0] load_dat;

  assign trig     = send | (in_q != prev_q);
  // busy_q with a ready shifter only happens on the last stop-bit cycle.
  assign byte_end = busy_q & u_ready;
  assign pkt_end  = byte_end & (idx_q == 2'd2);
  // Start from idle, or chain straight into the follow-up packet.
  assign start_now = (~busy_q & ~go_q & (trig | pending_q)) | (pkt_end & pending_q);

  assign load     = go_q | (byte_end & (idx_q != 2'd2));
  assign load_dat = go_q           ? HDR_BYTE :
                    (idx_q == 2'd0) ? snap_q   : (snap_q ^ HDR_BYTE);

  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      in_q      <= '0;
      prev_q    <= '0;
      snap_q    <= '0;
      idx_q     <= '0;
      go_q      <= 1'b0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      in_q   <= {SwitchManager, turn, speed};
      prev_q <= in_q;
      done_q <= pkt_end;
      go_q   <= start_now;
      if (start_now) snap_q <= {in_q[5], 2'b00, in_q[4], in_q[3:0]};

      // A trigger coinciding with a restart is already covered by that
      // restart's snapshot, so it is absorbed rather than re-queued.
      if (start_now)                   pending_q <= 1'b0;
      else if (trig & (busy_q | go_q)) pending_q <= 1'b1;

      if (go_q) begin
        busy_q <= 1'b1;
        idx_q  <= '0;
      end else if (pkt_end) begin
        busy_q <= 1'b0;
      end else if (byte_end) begin
        idx_q <= idx_q + 2'd1;
      end
    end
  end

  assign busy     = busy_q;
  assign pkt_done = done_q;

  uart_tx_byte #(.DIV(DIV)) u_byte (
    .clk100 (clk100),
    .reset  (reset),
    .load   (load),
    .data   (load_dat),
    .ready  (u_ready),
    .tx     (tx)
  );

endmodule
